// File: rtl/sparc_pkg.sv
// sparc_pkg: shared constants, fetch FSM states and instruction word type for the SPARC fetch slice.
package sparc_pkg;
    localparam int SPARC_ADDR_W = 9;
    localparam logic [31:0] SPARC_NOP = 32'h0100_0000;
    typedef enum logic {FILL, RUN} fetch_state_t;
    typedef logic [31:0] instr_t;
endpackage

// File: rtl/sparc_if_id_reg.sv
// sparc_if_id_reg: IF/ID pipeline register with load enable, bubble insert and sync reset.
module sparc_if_id_reg
    import sparc_pkg::*;
#(
    parameter int     ADDR_W   = SPARC_ADDR_W,
    parameter instr_t NOP_WORD = SPARC_NOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_annul,
    input  instr_t            i_instr,
    input  logic [ADDR_W-1:0] i_pc,
    output instr_t            o_instr,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_valid
);
    instr_t            r_instr;
    logic [ADDR_W-1:0] r_pc;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= NOP_WORD;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_annul ? NOP_WORD : i_instr;
            r_pc    <= i_pc;
            r_valid <= ~i_annul;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;
endmodule

// File: rtl/sparc_fetch_unit.sv
// sparc_fetch_unit: SPARC PC/nPC sequencing with delayed branch, stall hold and delay-slot annul.
module sparc_fetch_unit
    import sparc_pkg::*;
#(
    parameter int     ADDR_W   = SPARC_ADDR_W,
    parameter instr_t NOP_WORD = SPARC_NOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              annul_delay,
    output logic [ADDR_W-1:0] imem_addr,
    input  instr_t            imem_data,
    output instr_t            if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] npc_out
);
    fetch_state_t      r_state, w_next_state;
    logic [ADDR_W-1:0] r_pc, r_npc, w_target;
    logic              w_annul;

    always_ff @(posedge clk) begin
        r_state <= reset ? FILL : w_next_state;
    end

    always_comb begin
        w_next_state = stall ? r_state : RUN;
        w_annul      = (r_state == RUN) && annul_delay;
        w_target     = branch_target & ~ADDR_W'(3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= '0;
            r_npc <= ADDR_W'(4);
        end else if (!stall) begin
            r_pc  <= r_npc;
            r_npc <= branch_taken ? w_target : r_npc + ADDR_W'(4);
        end
    end

    sparc_if_id_reg #(.ADDR_W(ADDR_W), .NOP_WORD(NOP_WORD)) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .i_load  (~stall),
        .i_annul (w_annul),
        .i_instr (imem_data),
        .i_pc    (r_pc),
        .o_instr (if_id_instr),
        .o_pc    (if_id_pc),
        .o_valid (if_id_valid)
    );

    assign imem_addr = r_pc;
    assign npc_out   = r_npc;
endmodule

// File: tb/tb_sparc_fetch_unit.sv
// tb_sparc_fetch_unit: scoreboard bench; a fetch model queues expected state, a monitor compares.
module tb_sparc_fetch_unit;
    localparam int          AW  = 9;
    localparam logic [31:0] NOP = 32'h0100_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1, stall = 1'b0, branch_taken = 1'b0, annul_delay = 1'b0;
    logic [AW-1:0] branch_target = '0, imem_addr, if_id_pc, npc_out;
    logic [31:0]   imem_data, if_id_instr;
    logic          if_id_valid;
    logic [7:0]    rom [512];

    typedef struct packed {
        logic [AW-1:0] pc, npc, ipc;
        logic [31:0]   instr;
        logic          valid;
    } exp_t;
    exp_t q[$];

    int tests = 0, fails = 0;
    int m_pc = 0, m_npc = 4, m_ipc = 0;
    logic [31:0] m_instr = NOP;
    bit m_valid = 0, m_fill = 1;

    sparc_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .annul_delay(annul_delay), .imem_addr(imem_addr),
        .imem_data(imem_data), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid), .npc_out(npc_out)
    );

    always #5 clk = ~clk;

    assign imem_data = {rom[{imem_addr[AW-1:2], 2'd0}], rom[{imem_addr[AW-1:2], 2'd1}],
                        rom[{imem_addr[AW-1:2], 2'd2}], rom[{imem_addr[AW-1:2], 2'd3}]};

    function automatic logic [31:0] word(input int a);
        return {rom[a], rom[a+1], rom[a+2], rom[a+3]};
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", n, a, e, $time);
        end
    endtask

    // Model: fetch follows the PC/nPC pair; the word consumed is the one at PC before the edge.
    task automatic cyc(input bit rs, input bit st, input bit br, input int tgt, input bit an);
        reset = rs; stall = st; branch_taken = br; branch_target = tgt[AW-1:0]; annul_delay = an;
        @(posedge clk);
        if (rs) begin
            m_pc = 0; m_npc = 4; m_instr = NOP; m_ipc = 0; m_valid = 0; m_fill = 1;
        end else if (!st) begin
            bit kill;
            int nxt;
            kill = an && !m_fill;
            m_instr = kill ? NOP : word(m_pc);
            m_valid = !kill;
            m_ipc = m_pc;
            nxt = br ? (tgt % 512) / 4 * 4 : (m_npc + 4) % 512;
            m_pc = m_npc;
            m_npc = nxt;
            m_fill = 0;
        end
        q.push_back('{pc: m_pc[AW-1:0], npc: m_npc[AW-1:0], ipc: m_ipc[AW-1:0],
                      instr: m_instr, valid: m_valid});
        @(negedge clk);
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("imem_addr", 32'(imem_addr), 32'(e.pc));
            chk("npc_out", 32'(npc_out), 32'(e.npc));
            chk("if_id_pc", 32'(if_id_pc), 32'(e.ipc));
            chk("if_id_instr", if_id_instr, e.instr);
            chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = (i < 16) ? 8'(i + 1) : 8'($urandom);
        @(negedge clk);
        repeat (2) cyc(1, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 'h40, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 'h40, 0);
        cyc(0, 0, 0, 0, 1);
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 1, 'h80, 0);
        cyc(0, 0, 1, 'h80, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 1, 'h40, 0);
        cyc(0, 1, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 'h43, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 'h1F3, 0);
        repeat (6) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit rs, st, br, an;
            rs = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 25);
            br = !m_fill && ($urandom_range(0, 99) < 20);
            an = !m_fill && ($urandom_range(0, 99) < 15);
            cyc(rs, st, br, int'($urandom_range(0, 511)), an);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
